// File: rtl/chess_turn_ctrl.sv
// Turn controller for the two-player chess-clock counter block.
// Optional input conditioning: define CHESS_DEBOUNCE_EN.
module chess_turn_ctrl #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] preset,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       pause,
  input  logic       fin,
  output logic       enload,
  output logic [7:0] load_val,
  output logic       count1,
  output logic       count2,
  output logic       turn,
  output logic [1:0] loser,
  output logic [2:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  if (TICK_DIV < 4 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("chess_turn_ctrl: TICK_DIV must be >= 4, DEB_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN1  = 3'd3,
    S_RUN2  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_load_val;
  logic          r_count1;
  logic          r_count2;
  logic          r_turn;
  logic [1:0]    r_loser;
  logic [2:0]    w_lvl;
  logic [2:0]    r_lvl_q;
  logic [2:0]    w_edge;
  logic          w_tick;
  logic          w_wrap;
  logic          w_run;

  // w_lvl bit order: {start, btn2, btn1}
`ifdef CHESS_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_filt;
  logic [DW-1:0] r_deb [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      for (int i = 0; i < 3; i++) r_deb[i] <= '0;
    end else begin
      r_sync1 <= {start, btn2, btn1};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_deb[i] <= '0;
        end else if (r_deb[i] == DW'(DEB_CYCLES - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_deb[i]  <= '0;
        end else begin
          r_deb[i] <= r_deb[i] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = {start, btn2, btn1};
`endif

  assign w_edge = w_lvl & ~r_lvl_q;
  assign w_wrap = (r_presc == PW'(TICK_DIV - 1));
  assign w_run  = (r_state == S_RUN1) || (r_state == S_RUN2);

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_edge[2] && (preset != 8'd0)) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_READY;
      S_READY: begin
        if (!pause && w_edge[1]) w_next = S_RUN1;
      end
      S_RUN1: begin
        if (fin)                     w_next = S_DONE;
        else if (!pause && w_edge[0]) w_next = S_RUN2;
        else if (!pause && w_wrap)    w_tick = 1'b1;
      end
      S_RUN2: begin
        if (fin)                     w_next = S_DONE;
        else if (!pause && w_edge[1]) w_next = S_RUN1;
        else if (!pause && w_wrap)    w_tick = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_load_val <= '0;
      r_count1   <= 1'b0;
      r_count2   <= 1'b0;
      r_turn     <= 1'b0;
      r_loser    <= 2'b00;
      r_lvl_q    <= '0;
    end else begin
      r_state  <= w_next;
      r_lvl_q  <= w_lvl;
      r_count1 <= w_tick && (r_state == S_RUN1);
      r_count2 <= w_tick && (r_state == S_RUN2);
      // Partial periods are dropped on any state change
      if (w_next != r_state)  r_presc <= '0;
      else if (w_run && !pause) r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_next != r_state) begin
        unique case (w_next)
          S_LOAD: begin
            r_load_val <= preset;
            r_loser    <= 2'b00;
            r_turn     <= 1'b0;
          end
          S_RUN1: r_turn  <= 1'b0;
          S_RUN2: r_turn  <= 1'b1;
          S_DONE: r_loser <= r_turn ? 2'b10 : 2'b01;
          default: ;
        endcase
      end
    end
  end

  assign enload   = (r_state == S_LOAD);
  assign load_val = r_load_val;
  assign count1   = r_count1;
  assign count2   = r_count2;
  assign turn     = r_turn;
  assign loser    = r_loser;
  assign state    = r_state;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Directed bench for chess_turn_ctrl with TICK_DIV=4, default build.
module tb_chess_turn_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, btn1, btn2, pause, fin;
  logic [7:0] preset;
  logic       enload, count1, count2, turn;
  logic [7:0] load_val;
  logic [1:0] loser;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  chess_turn_ctrl #(.TICK_DIV(4), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .preset(preset),
    .btn1(btn1), .btn2(btn2), .pause(pause), .fin(fin),
    .enload(enload), .load_val(load_val), .count1(count1),
    .count2(count2), .turn(turn), .loser(loser), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] pre;
    logic       b1, b2, pa, fn;
    logic [2:0] es;
    logic       een;
    logic [7:0] elv;
    logic       ec1, ec2, etn;
    logic [1:0] els;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic st, logic [7:0] pre, logic b1, logic b2, logic pa, logic fn,
    logic [2:0] es, logic een, logic [7:0] elv,
    logic ec1, logic ec2, logic etn, logic [1:0] els);
    vec_t v;
    v.st = st; v.pre = pre; v.b1 = b1; v.b2 = b2; v.pa = pa; v.fn = fn;
    v.es = es; v.een = een; v.elv = elv;
    v.ec1 = ec1; v.ec2 = ec2; v.etn = etn; v.els = els;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic [2:0] es, logic een,
    logic [7:0] elv, logic ec1, logic ec2, logic etn, logic [1:0] els);
    chk({tag, ".state"}, int'(state), int'(es));
    chk({tag, ".enload"}, int'(enload), int'(een));
    chk({tag, ".load_val"}, int'(load_val), int'(elv));
    chk({tag, ".count1"}, int'(count1), int'(ec1));
    chk({tag, ".count2"}, int'(count2), int'(ec2));
    chk({tag, ".turn"}, int'(turn), int'(etn));
    chk({tag, ".loser"}, int'(loser), int'(els));
  endtask

  initial begin
    // start, pre, b1, b2, pause, fin | state, en, lv, c1, c2, turn, loser
    vt.push_back(mk(1,5,0,0,0,0, 1,1,5,0,0,0,0)); // start -> LOAD
    vt.push_back(mk(0,5,0,0,0,0, 2,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 2,0,5,0,0,0,0));
    vt.push_back(mk(0,5,1,0,0,0, 2,0,5,0,0,0,0)); // btn1 ignored
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0)); // btn2 -> RUN1
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,1,0,0,0)); // first pulse
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,1,0,0,0));
    vt.push_back(mk(0,5,1,0,0,0, 4,0,5,0,0,1,0)); // btn1 -> RUN2
    vt.push_back(mk(0,5,1,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,1,1,0)); // count2
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0)); // btn2 held
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,1,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,1,0,0,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,1,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,1,0,0, 3,0,5,0,0,0,0)); // switch beats wrap
    vt.push_back(mk(0,5,0,0,0,0, 3,0,5,0,0,0,0));
    vt.push_back(mk(0,5,1,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));
    vt.push_back(mk(0,5,0,0,0,0, 4,0,5,0,0,1,0));

    reset = 1'b1; start = 1'b0; preset = 8'd0;
    btn1 = 1'b0; btn2 = 1'b0; pause = 1'b0; fin = 1'b0;
    step();
    step();
    chk_all("reset", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    step();
    chk_all("idle", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00);

    foreach (vt[i]) begin
      start = vt[i].st; preset = vt[i].pre;
      btn1 = vt[i].b1; btn2 = vt[i].b2;
      pause = vt[i].pa; fin = vt[i].fn;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].es, vt[i].een, vt[i].elv,
              vt[i].ec1, vt[i].ec2, vt[i].etn, vt[i].els);
    end

    // Pause in RUN2 with prescaler at 2; btn2 pressed and held during it
    for (int i = 0; i < 20; i++) begin
      pause = 1'b1;
      btn2  = (i == 3) || (i >= 15);
      step();
      chk($sformatf("pause%0d.state", i), int'(state), 4);
      chk($sformatf("pause%0d.count2", i), int'(count2), 0);
    end
    pause = 1'b0;
    step();
    chk_all("resume0", 3'd4, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    chk_all("resume1", 3'd4, 1'b0, 8'd5, 1'b0, 1'b1, 1'b1, 2'b00);
    btn2 = 1'b0;
    step();
    btn2 = 1'b1;
    step();
    chk_all("to_run1", 3'd3, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 2'b00);

    // fin beats a btn1 edge in the same cycle
    btn2 = 1'b0; btn1 = 1'b1; fin = 1'b1;
    step();
    chk_all("fin_run1", 3'd5, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 2'b01);
    btn1 = 1'b0; fin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_all($sformatf("done%0d", i), 3'd5, 1'b0, 8'd5,
              1'b0, 1'b0, 1'b0, 2'b01);
    end

    start = 1'b1; preset = 8'd3;
    step();
    chk_all("restart", 3'd1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    start = 1'b0;
    step();
    chk_all("ready2", 3'd2, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    btn2 = 1'b1;
    step();
    btn2 = 1'b0; btn1 = 1'b1;
    step();
    chk_all("run2b", 3'd4, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 2'b00);
    btn1 = 1'b0; fin = 1'b1;
    step();
    chk_all("fin_run2", 3'd5, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 2'b10);
    fin = 1'b0; start = 1'b1; preset = 8'd0;
    step();
    chk_all("done_pre0", 3'd5, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 2'b10);
    start = 1'b0;

    reset = 1'b1;
    step();
    chk_all("reset2", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0; start = 1'b1; preset = 8'd0;
    step();
    chk_all("idle_pre0", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    start = 1'b0; fin = 1'b1;
    step();
    chk_all("idle_fin", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    fin = 1'b0; start = 1'b1; preset = 8'd7;
    step();
    chk_all("load7", 3'd1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 2'b00);
    start = 1'b0;
    step();
    btn2 = 1'b1;
    step();
    btn2 = 1'b0; btn1 = 1'b1;
    step();
    btn1 = 1'b0; start = 1'b1; preset = 8'd9;
    step();
    chk_all("run2_start", 3'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1, 2'b00);
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk_all("reset_run2", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("post%0d", i), 3'd0, 1'b0, 8'd0,
              1'b0, 1'b0, 1'b0, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
